// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase codes, lane indices and sequencer state for the traffic block
// Contents:
//   LS_*      4-bit light_signal phase codes (0 all red, 2L+1 green, 2L+2 yellow)
//   LANE_*    lane indices (NS=0, SN=1, EW=2, WE=3)
//   seq_state_t  sequencer state encoding
//   green_code / yellow_code  lane index to phase code helpers
package traffic_pkg;

  localparam logic [3:0] LS_ALL_RED = 4'd0;
  localparam logic [3:0] LS_NS_G    = 4'd1;
  localparam logic [3:0] LS_NS_Y    = 4'd2;
  localparam logic [3:0] LS_SN_G    = 4'd3;
  localparam logic [3:0] LS_SN_Y    = 4'd4;
  localparam logic [3:0] LS_EW_G    = 4'd5;
  localparam logic [3:0] LS_EW_Y    = 4'd6;
  localparam logic [3:0] LS_WE_G    = 4'd7;
  localparam logic [3:0] LS_WE_Y    = 4'd8;

  localparam logic [1:0] LANE_NS = 2'd0;
  localparam logic [1:0] LANE_SN = 2'd1;
  localparam logic [1:0] LANE_EW = 2'd2;
  localparam logic [1:0] LANE_WE = 2'd3;

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2
  } seq_state_t;

  function automatic logic [3:0] green_code(input logic [1:0] lane);
    return {1'b0, lane, 1'b1};
  endfunction

  function automatic logic [3:0] yellow_code(input logic [1:0] lane);
    return {1'b0, lane, 1'b0} + 4'd2;
  endfunction

endpackage

// File: rtl/lane_rr_arbiter.sv
// rtl/lane_rr_arbiter.sv - combinational round-robin pick of the next lane with demand
// Ports:
//   sensor  [3:0] in   lane demand, bit i = lane i
//   last    [1:0] in   lane granted most recently
//   next    [1:0] out  first requesting lane in order last+1, last+2, last+3, last
//   any_req       out  at least one sensor bit is set
module lane_rr_arbiter
  import traffic_pkg::*;
(
  input  logic [3:0] sensor,
  input  logic [1:0] last,
  output logic [1:0] next,
  output logic       any_req
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    next    = last;
    any_req = |sensor;
    found   = 1'b0;
    idx     = last;
    // Offset 4 wraps back to 'last', so the current lane is considered only after the other three.
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!found && sensor[idx]) begin
        next  = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/light_phase_sequencer.sv
// rtl/light_phase_sequencer.sv - adaptive round-robin traffic phase sequencer
// Ports:
//   clk            in   single clock, rising edge
//   rst            in   asynchronous active-high reset
//   tick           in   timebase enable; only tick cycles advance timers or state
//   sensor   [3:0] in   lane demand (NS, SN, EW, WE), sampled on ticks
//   preempt        in   emergency request: ends green, holds all-red
//   light_signal [3:0] out  registered phase code (0..8)
//   cur_lane [1:0] out  lane last granted green
//   phase_change   out  one-cycle pulse after every state transition
module light_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 20,
  parameter int YELLOW_T  = 3,
  parameter int ALL_RED_T = 1,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] sensor,
  input  logic       preempt,
  output logic [3:0] light_signal,
  output logic [1:0] cur_lane,
  output logic       phase_change
);

  localparam logic [CNT_W:0] MIN_G = (CNT_W+1)'(MIN_GREEN);
  localparam logic [CNT_W:0] MAX_G = (CNT_W+1)'(MAX_GREEN);
  localparam logic [CNT_W:0] YEL   = (CNT_W+1)'(YELLOW_T);
  localparam logic [CNT_W:0] ARED  = (CNT_W+1)'(ALL_RED_T);

  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   e;        // ticks spent in the state including this one; one extra bit so it never wraps
  logic [CNT_W-1:0] cnt_sat;  // saturating cnt+1
  logic [1:0]       rr_next;
  logic             rr_any;

  assign e       = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign cnt_sat = (&cnt) ? cnt : e[CNT_W-1:0];

  lane_rr_arbiter u_arb (
    .sensor  (sensor),
    .last    (cur_lane),
    .next    (rr_next),
    .any_req (rr_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_ALL_RED;
      cnt          <= '0;
      cur_lane     <= LANE_WE;
      light_signal <= LS_ALL_RED;
      phase_change <= 1'b0;
    end else if (!tick) begin
      phase_change <= 1'b0;
    end else begin
      phase_change <= 1'b0;
      case (state)
        ST_ALL_RED: begin
          // Demand arriving on the clearance-expiry tick is granted on that same tick.
          if (e >= ARED && !preempt && rr_any) begin
            state        <= ST_GREEN;
            cnt          <= '0;
            cur_lane     <= rr_next;
            light_signal <= green_code(rr_next);
            phase_change <= 1'b1;
          end else begin
            cnt <= cnt_sat;
          end
        end
        ST_GREEN: begin
          if (preempt || e >= MAX_G || (e >= MIN_G && !sensor[cur_lane])) begin
            state        <= ST_YELLOW;
            cnt          <= '0;
            light_signal <= yellow_code(cur_lane);
            phase_change <= 1'b1;
          end else begin
            cnt <= cnt_sat;
          end
        end
        ST_YELLOW: begin
          if (e >= YEL) begin
            state        <= ST_ALL_RED;
            cnt          <= '0;
            light_signal <= LS_ALL_RED;
            phase_change <= 1'b1;
          end else begin
            cnt <= cnt_sat;
          end
        end
        default: begin
          state        <= ST_ALL_RED;
          cnt          <= '0;
          light_signal <= LS_ALL_RED;
          phase_change <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_light_phase_sequencer.sv
// tb/tb_light_phase_sequencer.sv - self-checking bench for light_phase_sequencer
module tb_light_phase_sequencer;

  localparam int MIN_GREEN = 5;
  localparam int MAX_GREEN = 20;
  localparam int YELLOW_T  = 3;
  localparam int ALL_RED_T = 1;

  logic       clk;
  logic       rst;
  logic       tick;
  logic [3:0] sensor;
  logic       preempt;
  logic [3:0] light_signal;
  logic [1:0] cur_lane;
  logic       phase_change;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: phase 0 red, 1 green, 2 yellow; elapsed = completed ticks in phase.
  int m_phase;
  int m_elapsed;
  int m_lane;
  int m_light;
  int m_pc;

  light_phase_sequencer #(
    .MIN_GREEN (MIN_GREEN),
    .MAX_GREEN (MAX_GREEN),
    .YELLOW_T  (YELLOW_T),
    .ALL_RED_T (ALL_RED_T),
    .CNT_W     (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .sensor       (sensor),
    .preempt      (preempt),
    .light_signal (light_signal),
    .cur_lane     (cur_lane),
    .phase_change (phase_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase   = 0;
    m_elapsed = 0;
    m_lane    = 3;
    m_light   = 0;
    m_pc      = 0;
  endtask

  task automatic model_tick(input logic [3:0] s, input logic p);
    int e;
    e    = m_elapsed + 1;
    m_pc = 0;
    if (m_phase == 0) begin
      if (e >= ALL_RED_T && !p && s != 4'd0) begin
        for (int k = 1; k <= 4; k++) begin
          if (s[(m_lane + k) % 4]) begin
            m_lane = (m_lane + k) % 4;
            break;
          end
        end
        m_phase = 1; m_elapsed = 0; m_pc = 1;
      end else begin
        m_elapsed = e;
      end
    end else if (m_phase == 1) begin
      if (p || e >= MAX_GREEN || (e >= MIN_GREEN && !s[m_lane])) begin
        m_phase = 2; m_elapsed = 0; m_pc = 1;
      end else begin
        m_elapsed = e;
      end
    end else begin
      if (e >= YELLOW_T) begin
        m_phase = 0; m_elapsed = 0; m_pc = 1;
      end else begin
        m_elapsed = e;
      end
    end
    m_light = (m_phase == 0) ? 0 : 2 * m_lane + m_phase;
  endtask

  // Drive one cycle of inputs, advance the model on the edge, return 1 time unit after it.
  task automatic step(input logic t, input logic [3:0] s, input logic p);
    tick = t; sensor = s; preempt = p;
    @(posedge clk);
    if (t) model_tick(s, p);
    else   m_pc = 0;
    #1;
  endtask

  task automatic do_reset();
    tick = 1'b0; sensor = 4'd0; preempt = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (light_signal !== 4'd0) $display("FAIL reset_light got %0d want 0", light_signal);
    else pass_cnt++;
    total_cnt++;
    if (cur_lane !== 2'd3) $display("FAIL reset_lane got %0d want 3", cur_lane);
    else pass_cnt++;
    total_cnt++;
    if (phase_change !== 1'b0) $display("FAIL reset_pc got %0b want 0", phase_change);
    else pass_cnt++;
  endtask

  task automatic test_max_green_rotation();
    int lane, r, exp_l, exp_pc;
    do_reset();
    for (int i = 0; i < 192; i++) begin
      step(1'b1, 4'b1111, 1'b0);
      lane   = (i / 24) % 4;
      r      = i % 24;
      exp_l  = (r < 20) ? 2 * lane + 1 : (r < 23) ? 2 * lane + 2 : 0;
      exp_pc = (r == 0 || r == 20 || r == 23) ? 1 : 0;
      total_cnt++;
      if (light_signal !== 4'(exp_l))
        $display("FAIL rotation_light cycle %0d got %0d want %0d", i, light_signal, exp_l);
      else pass_cnt++;
      total_cnt++;
      if (phase_change !== 1'(exp_pc))
        $display("FAIL rotation_pc cycle %0d got %0b want %0d", i, phase_change, exp_pc);
      else pass_cnt++;
    end
  endtask

  task automatic test_short_demand();
    int exp_l;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, (i < 2) ? 4'b0100 : 4'b0000, 1'b0);
      exp_l = (i < 5) ? 5 : (i < 8) ? 6 : 0;
      total_cnt++;
      if (light_signal !== 4'(exp_l))
        $display("FAIL short_demand cycle %0d got %0d want %0d", i, light_signal, exp_l);
      else pass_cnt++;
    end
    total_cnt++;
    if (cur_lane !== 2'd2) $display("FAIL short_demand_lane got %0d want 2", cur_lane);
    else pass_cnt++;
  endtask

  task automatic test_sparse();
    int greens[$];
    logic [3:0] prev;
    do_reset();
    prev = light_signal;
    for (int i = 0; i < 300 && greens.size() < 3; i++) begin
      step(1'b1, 4'b1001, 1'b0);
      if (light_signal != prev && light_signal[0]) greens.push_back(int'(light_signal));
      prev = light_signal;
    end
    total_cnt++;
    if (greens.size() != 3) $display("FAIL sparse_count got %0d want 3", greens.size());
    else pass_cnt++;
    if (greens.size() == 3) begin
      total_cnt++;
      if (greens[0] != 1) $display("FAIL sparse_first got %0d want 1", greens[0]);
      else pass_cnt++;
      total_cnt++;
      if (greens[1] != 7) $display("FAIL sparse_skip got %0d want 7", greens[1]);
      else pass_cnt++;
      total_cnt++;
      if (greens[2] != 1) $display("FAIL sparse_wrap got %0d want 1", greens[2]);
      else pass_cnt++;
    end
  endtask

  task automatic test_preempt();
    do_reset();
    step(1'b1, 4'b1111, 1'b0);
    step(1'b1, 4'b1111, 1'b0);
    step(1'b1, 4'b1111, 1'b1);
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (light_signal !== 4'd2) $display("FAIL preempt_yellow %0d got %0d want 2", i, light_signal);
      else pass_cnt++;
      step(1'b1, 4'b1111, 1'b1);
    end
    for (int i = 0; i < 6; i++) begin
      total_cnt++;
      if (light_signal !== 4'd0) $display("FAIL preempt_hold %0d got %0d want 0", i, light_signal);
      else pass_cnt++;
      step(1'b1, 4'($urandom_range(0, 15)), 1'b1);
    end
    total_cnt++;
    if (light_signal !== 4'd0) $display("FAIL preempt_hold_end got %0d want 0", light_signal);
    else pass_cnt++;
    step(1'b1, 4'b1111, 1'b0);
    total_cnt++;
    if (light_signal !== 4'd3) $display("FAIL preempt_resume got %0d want 3", light_signal);
    else pass_cnt++;
  endtask

  task automatic test_slow_tick();
    logic [3:0] prev_l;
    logic [1:0] prev_lane;
    int run_len, runs_seen, green_run, yellow_run;
    logic t;
    do_reset();
    prev_l = light_signal; run_len = 0; runs_seen = 0; green_run = -1; yellow_run = -1;
    for (int c = 0; c < 500; c++) begin
      t = (c % 10 == 0);
      prev_lane = cur_lane;
      step(t, 4'b0001, 1'b0);
      total_cnt++;
      if (light_signal !== 4'(m_light) || cur_lane !== 2'(m_lane) || phase_change !== 1'(m_pc))
        $display("FAIL slow_model cycle %0d got l=%0d lane=%0d pc=%0b want l=%0d lane=%0d pc=%0d",
                 c, light_signal, cur_lane, phase_change, m_light, m_lane, m_pc);
      else pass_cnt++;
      if (!t) begin
        total_cnt++;
        if (light_signal !== prev_l || cur_lane !== prev_lane || phase_change !== 1'b0)
          $display("FAIL slow_nontick cycle %0d got l=%0d pc=%0b want l=%0d pc=0",
                   c, light_signal, phase_change, prev_l);
        else pass_cnt++;
      end
      if (light_signal != prev_l) begin
        if (prev_l == 4'd1 && green_run < 0)  green_run  = run_len;
        if (prev_l == 4'd2 && yellow_run < 0) yellow_run = run_len;
        run_len = 1;
      end else begin
        run_len++;
      end
      prev_l = light_signal;
    end
    total_cnt++;
    if (green_run != 10 * MAX_GREEN) $display("FAIL slow_green_len got %0d want %0d", green_run, 10 * MAX_GREEN);
    else pass_cnt++;
    total_cnt++;
    if (yellow_run != 10 * YELLOW_T) $display("FAIL slow_yellow_len got %0d want %0d", yellow_run, 10 * YELLOW_T);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int guard;
    do_reset();
    guard = 0;
    while (light_signal !== 4'd2 && guard < 50) begin
      step(1'b1, 4'b1111, 1'b0);
      guard++;
    end
    total_cnt++;
    if (light_signal !== 4'd2) $display("FAIL areset_reach_yellow got %0d want 2", light_signal);
    else pass_cnt++;
    step(1'b1, 4'b1111, 1'b0);
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (light_signal !== 4'd0 || cur_lane !== 2'd3 || phase_change !== 1'b0)
      $display("FAIL areset_immediate got l=%0d lane=%0d pc=%0b want l=0 lane=3 pc=0",
               light_signal, cur_lane, phase_change);
    else pass_cnt++;
    #2 rst = 1'b0;
    model_reset();
    step(1'b1, 4'b1111, 1'b0);
    total_cnt++;
    if (light_signal !== 4'd1 || cur_lane !== 2'd0)
      $display("FAIL areset_first_grant got l=%0d lane=%0d want l=1 lane=0", light_signal, cur_lane);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic       t, p;
    logic [3:0] s;
    int         pre_left;
    do_reset();
    pre_left = 0;
    for (int c = 0; c < 3000; c++) begin
      t = ($urandom_range(0, 2) != 0);
      s = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      if (pre_left == 0 && $urandom_range(0, 60) == 0) pre_left = $urandom_range(1, 12);
      p = (pre_left != 0);
      if (pre_left != 0) pre_left--;
      step(t, s, p);
      total_cnt++;
      if (light_signal !== 4'(m_light) || cur_lane !== 2'(m_lane) || phase_change !== 1'(m_pc))
        $display("FAIL random_model cycle %0d got l=%0d lane=%0d pc=%0b want l=%0d lane=%0d pc=%0d",
                 c, light_signal, cur_lane, phase_change, m_light, m_lane, m_pc);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; sensor = 4'd0; preempt = 1'b0;
    model_reset();
    test_reset();
    test_max_green_rotation();
    test_short_demand();
    test_sparse();
    test_preempt();
    test_slow_tick();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
